// File: rtl/cnt_rpt_pkg.sv
// cnt_rpt_pkg: shared types, constants and hex helper for the counter UART reporter.
// CNT_RPT_PARITY_EN selects 8E1 framing (11 bit times per byte) instead of 8N1.
package cnt_rpt_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int FRAME_LEN = 6;
`ifdef CNT_RPT_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'(8'h37 + {4'h0, n});
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte UART transmitter; accepts the next byte on the edge the
// current stop bit ends so bytes go out back-to-back. Parity via CNT_RPT_PARITY_EN.
module uart_tx_byte
  import cnt_rpt_pkg::*;
#(
  parameter int P_CLKS_PER_BIT = 347
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_txd
);
  localparam int SW = BITS_PER_BYTE - 1;
  logic [11:0]   baud_q, baud_d;
  logic [3:0]    bits_q, bits_d;
  logic [SW-1:0] shift_q, shift_d, load;
  logic          busy_q, busy_d, txd_q, txd_d, tick, last;
  // baud divider, bit sequencing and load of the next byte
  always_comb begin
`ifdef CNT_RPT_PARITY_EN
    load = {1'b1, ^i_data, i_data};
`else
    load = {1'b1, i_data};
`endif
    tick = baud_q == 12'(P_CLKS_PER_BIT - 1);
    last = tick && bits_q == 4'd0;
    o_ready = !busy_q || last;
    baud_d = (!busy_q || tick) ? 12'd0 : baud_q + 12'd1;
    bits_d = bits_q;
    shift_d = shift_q;
    busy_d = busy_q;
    txd_d = txd_q;
    if (o_ready && i_valid) begin
      busy_d = 1'b1;
      txd_d = 1'b0;
      bits_d = 4'(SW);
      shift_d = load;
    end else if (last) begin
      busy_d = 1'b0;
      txd_d = 1'b1;
    end else if (busy_q && tick) begin
      txd_d = shift_q[0];
      shift_d = shift_q >> 1;
      bits_d = bits_q - 4'd1;
    end
  end
  // transmitter registers; reset forces the line idle and drops any byte in flight
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      baud_q <= '0;
      bits_q <= '0;
      shift_q <= '0;
      busy_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      baud_q <= baud_d;
      bits_q <= bits_d;
      shift_q <= shift_d;
      busy_q <= busy_d;
      txd_q <= txd_d;
    end
  end
  assign o_txd = txd_q;
endmodule

// File: rtl/cnt_uart_reporter.sv
// cnt_uart_reporter: reports the 16-bit counter as "HHHH\r\n" over UART on change or forced send.
// CNT_RPT_PARITY_EN (in cnt_rpt_pkg / uart_tx_byte) selects 8E1 framing.
module cnt_uart_reporter
  import cnt_rpt_pkg::*;
#(
  parameter int P_CLKS_PER_BIT = 347
) (
  input  logic        i_clk,
  input  logic        i_res_n,
  input  logic [15:0] i_cnt,
  input  logic        i_send,
  output logic        o_txd,
  output logic        o_busy
);
  state_e      state_q, state_d;
  logic [15:0] prev_q, prev_d, snap_q, snap_d;
  logic [2:0]  idx_q, idx_d, nxt;
  logic [3:0]  nib;
  logic [7:0]  tx_data;
  logic        pend_q, pend_d, trig, start, tx_ready, tx_valid;
  // change detection, pending slot and byte sequencing; a frame may restart on its own last edge
  always_comb begin
    trig = (i_cnt != prev_q) || i_send;
    nxt = idx_q + 3'd1;
    nib = nxt[1:0] == 2'd1 ? snap_q[11:8] : nxt[1:0] == 2'd2 ? snap_q[7:4] : snap_q[3:0];
    start = state_q == IDLE ? trig
          : tx_ready && idx_q == 3'(FRAME_LEN - 1) && (pend_q || trig);
    state_d = state_q;
    prev_d = prev_q;
    snap_d = snap_q;
    idx_d = idx_q;
    pend_d = pend_q;
    tx_valid = 1'b0;
    tx_data = hex_ascii(i_cnt[15:12]);
    if (start) begin
      state_d = SEND;
      prev_d = i_cnt;
      snap_d = i_cnt;
      idx_d = 3'd0;
      pend_d = 1'b0;
      tx_valid = 1'b1;
    end else if (state_q == SEND) begin
      pend_d = pend_q || trig;
      if (tx_ready && idx_q == 3'(FRAME_LEN - 1)) state_d = IDLE;
      else if (tx_ready) begin
        tx_valid = 1'b1;
        idx_d = nxt;
        tx_data = nxt == 3'd4 ? ASCII_CR : nxt == 3'd5 ? ASCII_LF : hex_ascii(nib);
      end
    end
  end
  // sequencer registers
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_q <= IDLE;
      prev_q <= '0;
      snap_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      snap_q <= snap_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
    end
  end
  uart_tx_byte #(.P_CLKS_PER_BIT(P_CLKS_PER_BIT)) u_tx (
    .i_clk  (i_clk),
    .i_res_n(i_res_n),
    .i_valid(tx_valid),
    .i_data (tx_data),
    .o_ready(tx_ready),
    .o_txd  (o_txd)
  );
  assign o_busy = state_q == SEND;
endmodule

// File: tb/tb_cnt_uart_reporter.sv
// tb_cnt_uart_reporter: directed self-checking bench decoding the UART line against hand-built frames.
module tb_cnt_uart_reporter;
  localparam int P = 16;
`ifdef CNT_RPT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = 6 * NB * P;
  typedef logic [7:0] frame_t [6];
  logic clk = 0, res_n = 0, send = 0;
  logic [15:0] cnt = 16'h0000;
  logic txd, busy;
  int checks = 0, failures = 0, cyc = 0, run = 0, last_run = 0;
  int t0, t1, t2;
  frame_t f;
  cnt_uart_reporter #(.P_CLKS_PER_BIT(P)) dut (
    .i_clk(clk), .i_res_n(res_n), .i_cnt(cnt), .i_send(send), .o_txd(txd), .o_busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic quiet(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      tick(1);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3 * FRAME) begin
      tick(1);
      n++;
    end
    check("idle_reached", busy, 0);
    tick(2);
  endtask
  task automatic recv_frame(input frame_t exp, output int t_first);
    logic [7:0] got;
    int n, t, tprev;
    tprev = 0;
    t_first = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (txd !== 1'b0 && n < 2 * NB * P) begin
        tick(1);
        n++;
      end
      check($sformatf("start_seen%0d", k), txd, 0);
      t = cyc;
      if (k == 0) t_first = t;
      else check($sformatf("byte_space%0d", k), t - tprev, NB * P);
      tprev = t;
      tick(P / 2);
      check($sformatf("start_mid%0d", k), txd, 0);
      for (int i = 0; i < 8; i++) begin
        tick(P);
        got[i] = txd;
      end
`ifdef CNT_RPT_PARITY_EN
      tick(P);
      check($sformatf("parity%0d", k), txd, ^exp[k]);
`endif
      tick(P);
      check($sformatf("stop%0d", k), txd, 1);
      check($sformatf("byte%0d", k), got, exp[k]);
    end
  endtask
  initial begin
    tick(3);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    res_n = 1;
    quiet(2000, "idle_quiet");
    cnt = 16'h1A2F;
    tick(1);
    check("lat_busy", busy, 1);
    check("lat_txd", txd, 0);
    f = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    fork
      recv_frame(f, t0);
      begin
        tick(100);
        cnt = 16'h1A30;
        tick(100);
        cnt = 16'h1A31;
      end
    join
    f = '{8'h31, 8'h41, 8'h33, 8'h31, 8'h0D, 8'h0A};
    recv_frame(f, t1);
    check("chain_gap", t1 - t0, FRAME);
    wait_idle();
    check("busy_len_chain", last_run, 2 * FRAME);
    quiet(3 * NB * P, "no_third_frame");
    cnt = 16'h00FF;
    f = '{8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A};
    recv_frame(f, t2);
    wait_idle();
    check("busy_len_00ff", last_run, FRAME);
    quiet(200, "steady_quiet");
    for (int r = 0; r < 2; r++) begin
      send = 1;
      tick(1);
      send = 0;
      check("send_busy", busy, 1);
      recv_frame(f, t2);
      wait_idle();
      check("busy_len_send", last_run, FRAME);
      quiet(200, "send_quiet");
    end
    cnt = 16'h0007;
    send = 1;
    tick(1);
    send = 0;
    f = '{8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
    recv_frame(f, t2);
    wait_idle();
    check("busy_len_0007", last_run, FRAME);
    quiet(3 * NB * P, "single_report");
    cnt = 16'h1234;
    tick(1);
    tick(2 * NB * P + 3 * P);
    check("pre_rst_busy", busy, 1);
    res_n = 0;
    tick(1);
    check("abort_txd", txd, 1);
    check("abort_busy", busy, 0);
    res_n = 1;
    tick(1);
    check("restart_busy", busy, 1);
    check("restart_txd", txd, 0);
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    recv_frame(f, t2);
    wait_idle();
    check("busy_len_1234", last_run, FRAME);
    quiet(3 * NB * P, "post_rst_quiet");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
